// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU front-end types: the fetch queue entry and the decoder's output record.
// The fetch queue and the decoder both import this package so they agree on field layout.
package inst_fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fetch_ex;
    } fetch_entry_t;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH,
        OP_JUMP,
        OP_SYSTEM,
        OP_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic [31:0] pc;
        op_class_t   op_class;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        fetch_ex;
    } decoded_inst_t;

    function automatic fetch_entry_t make_fetch_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        fetch_ex
    );
        fetch_entry_t e;
        e.pc       = pc;
        e.inst     = inst;
        e.fetch_ex = fetch_ex;
        return e;
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between fetch and decode: a registered FIFO of fetch_entry_t
// with flush for redirects. The head entry is presented combinationally from storage.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    input  logic                       in_fetch_ex,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic                       out_fetch_ex,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t  entries [DEPTH];
    fetch_entry_t  head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Readiness looks only at registered occupancy, so a full queue never accepts
    // a push even when the decoder drains the head in the same cycle.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign head         = entries[rd_ptr];
    assign out_pc       = head.pc;
    assign out_inst     = head.inst;
    assign out_fetch_ex = head.fetch_ex;

    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= make_fetch_entry(in_pc, in_inst, in_fetch_ex);
        end
    end

    // Pointers are exactly PW bits wide, so they wrap from DEPTH-1 to 0 on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_fetch_ex;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fetch_ex;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t model[$];

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .in_fetch_ex  (in_fetch_ex),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_fetch_ex (out_fetch_ex),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, checks the DUT against the model mid-cycle,
    // then advances the model by the queue rules at the clock edge.
    task automatic applyStimulus(
        input logic        r,
        input logic        f,
        input logic        iv,
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        ex,
        input logic        ordy
    );
        bit do_push;
        bit do_pop;
        fetch_entry_t e;
        rst         = r;
        flush       = f;
        in_valid    = iv;
        in_pc       = pc;
        in_inst     = inst;
        in_fetch_ex = ex;
        out_ready   = ordy;
        @(negedge clk);
        checkOutput("count", 64'(count), 64'(model.size()));
        checkOutput("in_ready", 64'(in_ready), 64'(model.size() != DEPTH));
        checkOutput("out_valid", 64'(out_valid), 64'(model.size() != 0));
        if (model.size() != 0) begin
            checkOutput("out_pc", 64'(out_pc), 64'(model[0].pc));
            checkOutput("out_inst", 64'(out_inst), 64'(model[0].inst));
            checkOutput("out_fetch_ex", 64'(out_fetch_ex), 64'(model[0].fetch_ex));
        end
        do_push = iv && !f && (model.size() != DEPTH);
        do_pop  = ordy && !f && (model.size() != 0);
        e.pc       = pc;
        e.inst     = inst;
        e.fetch_ex = ex;
        @(posedge clk);
        if (r || f) begin
            model.delete();
        end else begin
            if (do_pop) model.delete(0);
            if (do_push) model.push_back(e);
        end
        #1;
    endtask

    initial begin
        int pin;
        int pout;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        in_fetch_ex = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);

        // Three pushes with the decoder stalled.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 1, 32'hBFC00000 + 32'(4 * i), $urandom, 0, 0);
        checkOutput("three_count", 64'(count), 64'd3);
        checkOutput("three_head_pc", 64'(out_pc), 64'hBFC00000);
        checkOutput("three_in_ready", 64'(in_ready), 64'd1);

        // Fill to capacity; a ninth push must be dropped.
        for (int i = 3; i < 8; i++)
            applyStimulus(0, 0, 1, 32'hBFC00000 + 32'(4 * i), $urandom, 0, 0);
        checkOutput("full_count", 64'(count), 64'd8);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(0, 0, 1, 32'hDEAD0000, $urandom, 0, 0);
        checkOutput("ninth_dropped", 64'(count), 64'd8);

        // Full with push and pop together: only the pop happens.
        applyStimulus(0, 0, 1, 32'hDEAD0004, $urandom, 0, 1);
        checkOutput("full_pushpop_count", 64'(count), 64'd7);
        checkOutput("full_pushpop_head", 64'(out_pc), 64'hBFC00004);

        // Drain down to four, then stream push+pop so pointers wrap.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 1);
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 0, 1, 32'h00400000 + 32'(4 * i), $urandom, 0, 1);
        checkOutput("stream_count", 64'(count), 64'd4);
        checkOutput("stream_head", 64'(out_pc), 64'h00400018);

        // Flush at count 5 overrides a concurrent push and pop.
        applyStimulus(0, 0, 1, 32'h00500000, $urandom, 0, 0);
        checkOutput("pre_flush_count", 64'(count), 64'd5);
        applyStimulus(0, 1, 1, 32'h00600000, $urandom, 0, 1);
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);

        // Exception-flagged entry with a zero instruction word, then reset mid-stream.
        applyStimulus(0, 0, 1, 32'h80000180, 32'h00000000, 1, 0);
        checkOutput("ex_flag", 64'(out_fetch_ex), 64'd1);
        checkOutput("ex_inst", 64'(out_inst), 64'd0);
        applyStimulus(0, 0, 1, 32'h80000184, $urandom, 0, 0);
        applyStimulus(1, 0, 1, 32'h80000188, $urandom, 0, 1);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        // Random traffic with phase-varying push/pop bias to visit full and empty often.
        for (int p = 0; p < 6; p++) begin
            pin  = (p % 3 == 0) ? 85 : ((p % 3 == 1) ? 30 : 60);
            pout = (p % 3 == 0) ? 30 : ((p % 3 == 1) ? 85 : 60);
            for (int c = 0; c < 400; c++) begin
                applyStimulus($urandom_range(0, 199) == 0,
                              $urandom_range(0, 39) == 0,
                              $urandom_range(0, 99) < pin,
                              $urandom, $urandom,
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 99) < pout);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  discard all entries (exception/branch redirect).
REQ-005 SHALL have port in_valid  input  1  fetch stage presents an instruction.
REQ-006 SHALL have port in_ready  output  1  queue accepts a push this cycle.
REQ-007 SHALL have port in_pc  input  32  PC of pushed instruction.
REQ-008 SHALL have port in_inst  input  32  uint32_t raw instruction word.
REQ-009 SHALL have port in_fetch_ex  input  1  fetch-side exception flag (AdEL/TLB), carried with entry.
REQ-010 SHALL have port out_valid  output  1  head entry available to the decoder.
REQ-011 SHALL have port out_ready  input  1  decoder consumes head this cycle.
REQ-012 SHALL have port out_pc  output  32  head entry PC.
REQ-013 SHALL have port out_inst  output  32  head entry instruction word, fed to decoder inst input.
REQ-014 SHALL have port out_fetch_ex  output  1  head entry exception flag.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-017 in_ready SHALL equal (count != DEPTH); depends only on registered state, never on out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_pc/out_inst/out_fetch_ex SHALL reflect the entry at read pointer, combinationally from storage.
REQ-019 Latency: an entry pushed at edge N SHALL be visible on outputs (out_valid=1) after edge N; no same-cycle bypass.
REQ-020 Order SHALL be strict FIFO; entry contents SHALL never be modified after push.
REQ-021 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 count next = count + push - pop; simultaneous push and pop SHALL leave count unchanged and both pointers advance.
REQ-023 Full (count==DEPTH): in_ready=0, push refused even if pop in same cycle; pop proceeds normally.
REQ-024 Empty (count==0): out_valid=0; out_ready ignored; outputs contents don't-care.
REQ-025 flush SHALL set count=0 and both pointers to 0 at next edge, overriding any push/pop that cycle; out_valid=0 the cycle after.
REQ-026 When out_valid=0, outputs SHALL not be interpreted; decoder treats the slot as a bubble.

Reset
REQ-027 On rst=1 at an edge: count=0, read/write pointers=0, so out_valid=0 and in_ready=1 next cycle.
REQ-028 rst SHALL take priority over flush, push and pop; asserting rst mid-operation discards all entries.
REQ-029 Storage array SHALL not require reset; only pointers and count are reset.

Structure
REQ-030 The entry typedef fetch_entry_t {pc, inst, fetch_ex} SHALL live in the shared cpu package header alongside decoded_inst_t.
REQ-031 No sub-module: storage is an inline array of fetch_entry_t; pointer/count logic in one sequential process.

Verification
REQ-032 Reset then push 3 entries (pc 0xBFC00000/04/08, out_ready=0) -> count=3, out_pc=0xBFC00000, in_ready=1.
REQ-033 Push 8 with out_ready=0 -> count=8, in_ready=0; 9th push with in_valid=1 is dropped; drain yields pcs in push order.
REQ-034 Full queue, in_valid=1 and out_ready=1 same cycle -> pop only, count 8->7, new entry not stored.
REQ-035 count=4, simultaneous push+pop for 10 cycles -> count stays 4, pointers wrap past 7->0, order preserved.
REQ-036 count=5, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, pushed entry absent.
REQ-037 Push entry with in_fetch_ex=1, inst 0x00000000 -> out_fetch_ex=1 at head; rst mid-stream -> count=0, in_ready=1.
